// File: rtl/ram_rr_arbiter.sv
// Two-requester read / two-requester write round-robin arbiter in front of a 1R1W sync RAM.
// After reset the whole RAM is cleared to zero before any request is granted.
`timescale 1ns/1ps
module ram_rr_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          rd_req,
  input  logic [2*ADDR_W-1:0] rd_addr,
  output logic [1:0]          rd_gnt,
  output logic [1:0]          rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  input  logic [1:0]          wr_req,
  input  logic [2*ADDR_W-1:0] wr_addr,
  input  logic [2*DATA_W-1:0] wr_data,
  output logic [1:0]          wr_gnt,
  output logic                init_done,
  output logic [ADDR_W-1:0]   ram_raddr,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [ADDR_W-1:0]   ram_waddr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic                ram_we
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                init_done_q, init_done_d;
  logic [1:0]          rd_valid_q;

  logic [1:0]          rd_gnt_s, wr_gnt_s;
  logic [ADDR_W-1:0]   ram_raddr_s, ram_waddr_s;
  logic [DATA_W-1:0]   ram_wdata_s;
  logic                ram_we_s;

  // On contention the pointer names the winner; a sole requester always wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
    logic [1:0] gnt;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    return gnt;
  endfunction

  function automatic logic next_ptr(input logic [1:0] gnt, input logic ptr);
    logic p;
    case (gnt)
      2'b01:   p = 1'b1;
      2'b10:   p = 1'b0;
      default: p = ptr;
    endcase
    return p;
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      init_done_q <= 1'b0;
      rd_valid_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      init_done_q <= init_done_d;
      rd_valid_q  <= rd_gnt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST_ADDR) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        rd_ptr_d = next_ptr(rd_gnt_s, rd_ptr_q);
        wr_ptr_d = next_ptr(wr_gnt_s, wr_ptr_q);
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: clear sweep in INIT, arbitration and RAM port muxing in RUN
  always_comb begin
    rd_gnt_s    = 2'b00;
    wr_gnt_s    = 2'b00;
    ram_raddr_s = '0;
    ram_waddr_s = '0;
    ram_wdata_s = '0;
    ram_we_s    = 1'b0;
    case (state_q)
      ST_INIT: begin
        ram_we_s    = 1'b1;
        ram_waddr_s = cnt_q;
      end
      ST_RUN: begin
        rd_gnt_s = rr_pick(rd_req, rd_ptr_q);
        wr_gnt_s = rr_pick(wr_req, wr_ptr_q);
        if (rd_gnt_s[1]) begin
          ram_raddr_s = rd_addr[2*ADDR_W-1:ADDR_W];
        end else if (rd_gnt_s[0]) begin
          ram_raddr_s = rd_addr[ADDR_W-1:0];
        end else begin
          ram_raddr_s = '0;
        end
        if (wr_gnt_s[1]) begin
          ram_we_s    = 1'b1;
          ram_waddr_s = wr_addr[2*ADDR_W-1:ADDR_W];
          ram_wdata_s = wr_data[2*DATA_W-1:DATA_W];
        end else if (wr_gnt_s[0]) begin
          ram_we_s    = 1'b1;
          ram_waddr_s = wr_addr[ADDR_W-1:0];
          ram_wdata_s = wr_data[DATA_W-1:0];
        end else begin
          ram_we_s    = 1'b0;
        end
      end
      default: begin
        ram_we_s = 1'b0;
      end
    endcase
  end

  // The INIT clear must not write while reset is held.
  assign ram_we    = ram_we_s & reset_n;
  assign ram_waddr = ram_waddr_s;
  assign ram_wdata = ram_wdata_s;
  assign ram_raddr = ram_raddr_s;
  assign rd_gnt    = rd_gnt_s;
  assign wr_gnt    = wr_gnt_s;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = ram_rdata;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter: a RAM model, a behavioural arbiter model checked every
// cycle, and hand-computed expectations for the key scenarios.
`timescale 1ns/1ps
module tb_ram_rr_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset_n;
  logic [1:0] rd_req, wr_req;
  logic [2*AW-1:0] rd_addr, wr_addr;
  logic [2*DW-1:0] wr_data;
  logic [1:0] rd_gnt, rd_valid, wr_gnt;
  logic [DW-1:0] rd_data, ram_rdata, ram_wdata;
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic ram_we, init_done;

  // second instance with a short RAM, inputs idle
  logic [1:0] req8;
  logic [5:0] addr8;
  logic [63:0] wdata8;
  logic [31:0] rdata8;
  logic [1:0] rd_gnt8, rd_valid8, wr_gnt8;
  logic [31:0] rd_data8, ram_wdata8;
  logic [2:0] ram_raddr8, ram_waddr8;
  logic ram_we8, init_done8;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .init_done(init_done), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we));

  ram_rr_arbiter #(.ADDR_W(3), .DATA_W(32), .DEPTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n),
    .rd_req(req8), .rd_addr(addr8), .rd_gnt(rd_gnt8), .rd_valid(rd_valid8), .rd_data(rd_data8),
    .wr_req(req8), .wr_addr(addr8), .wr_data(wdata8), .wr_gnt(wr_gnt8),
    .init_done(init_done8), .ram_raddr(ram_raddr8), .ram_rdata(rdata8),
    .ram_waddr(ram_waddr8), .ram_wdata(ram_wdata8), .ram_we(ram_we8));

  // 1R1W synchronous RAM, preloaded with junk so the clear is observable
  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA5A50000 | i;
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cnt;             // entries cleared so far
  bit m_done;
  int m_rpref, m_wpref;  // index that wins the next contention
  logic [1:0] m_rv;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] mm [DEPTH];

  function automatic int winner(input logic [1:0] req, input int pref);
    if (req == 2'b11) return pref;
    if (req == 2'b01) return 0;
    if (req == 2'b10) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] onehot(input int w);
    logic [1:0] one;
    one = 2'b01;
    return (w < 0) ? 2'b00 : (one << w);
  endfunction

  always @(negedge clk) begin
    int rw, ww;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd;
    if (!reset_n) begin
      chk("m_rst_rd_gnt", 64'(rd_gnt), 64'd0);
      chk("m_rst_wr_gnt", 64'(wr_gnt), 64'd0);
      chk("m_rst_ram_we", 64'(ram_we), 64'd0);
      chk("m_rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("m_rst_init_done", 64'(init_done), 64'd0);
      m_cnt = 0; m_done = 0; m_rpref = 0; m_wpref = 0; m_rv = 2'b00; m_rdata = '0;
    end else begin
      chk("m_init_done", 64'(init_done), 64'(m_done));
      chk("m_rd_valid", 64'(rd_valid), 64'(m_rv));
      if (m_rv != 2'b00) chk("m_rd_data", 64'(rd_data), 64'(m_rdata));
      if (m_cnt < DEPTH) begin
        chk("m_clr_we", 64'(ram_we), 64'd1);
        chk("m_clr_waddr", 64'(ram_waddr), 64'(m_cnt));
        chk("m_clr_wdata", 64'(ram_wdata), 64'd0);
        chk("m_clr_rd_gnt", 64'(rd_gnt), 64'd0);
        chk("m_clr_wr_gnt", 64'(wr_gnt), 64'd0);
        mm[m_cnt] = '0;
        m_cnt++;
        m_done = (m_cnt == DEPTH);
        m_rv = 2'b00;
      end else begin
        rw = winner(rd_req, m_rpref);
        ww = winner(wr_req, m_wpref);
        ra = (rw < 0) ? '0 : rd_addr[rw*AW +: AW];
        wa = (ww < 0) ? '0 : wr_addr[ww*AW +: AW];
        wd = (ww < 0) ? '0 : wr_data[ww*DW +: DW];
        chk("m_rd_gnt", 64'(rd_gnt), 64'(onehot(rw)));
        chk("m_wr_gnt", 64'(wr_gnt), 64'(onehot(ww)));
        chk("m_ram_raddr", 64'(ram_raddr), 64'(ra));
        chk("m_ram_we", 64'(ram_we), 64'(ww >= 0));
        chk("m_ram_waddr", 64'(ram_waddr), 64'(wa));
        chk("m_ram_wdata", 64'(ram_wdata), 64'(wd));
        m_rv = onehot(rw);
        if (rw >= 0) begin m_rdata = mm[ra]; m_rpref = 1 - rw; end
        if (ww >= 0) begin mm[wa] = wd; m_wpref = 1 - ww; end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_init();
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k <= 32) begin
        chk("lit_clr_we", 64'(ram_we), 64'd1);
        chk("lit_clr_waddr", 64'(ram_waddr), 64'(k - 1));
        chk("lit_clr_no_gnt", 64'({rd_gnt, wr_gnt}), 64'd0);
        chk("lit_clr_not_done", 64'(init_done), 64'd0);
      end else begin
        chk("lit_done_c33", 64'(init_done), 64'd1);
      end
      if (k <= 8) chk("lit8_clr_waddr", 64'(ram_waddr8), 64'(k - 1));
      if (k == 8) chk("lit8_not_done_c8", 64'(init_done8), 64'd0);
      if (k == 9) chk("lit8_done_c9", 64'(init_done8), 64'd1);
      tick();
      if (k == 32) begin rd_req = 2'b00; wr_req = 2'b00; end
    end
  endtask

  initial begin
    logic [1:0] wexp [4];
    logic [1:0] wreq [4];
    wexp = '{2'b10, 2'b10, 2'b01, 2'b10};
    wreq = '{2'b10, 2'b10, 2'b11, 2'b11};
    req8 = 2'b00; addr8 = '0; wdata8 = '0; rdata8 = '0;
    reset_n = 1'b0;
    rd_req = 2'b11; wr_req = 2'b11;
    rd_addr = {5'd7, 5'd3}; wr_addr = {5'd7, 5'd3};
    wr_data = {32'h77777777, 32'h11111111};
    @(negedge clk);
    chk("lit_rst_we", 64'(ram_we), 64'd0);
    chk("lit_rst_rd_gnt", 64'(rd_gnt), 64'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    run_init();

    // populate addr 3 and 7 through a write contention
    wr_req = 2'b11;
    @(negedge clk);
    chk("lit_wr_first", 64'(wr_gnt), 64'h1);
    chk("lit_wr_first_addr", 64'(ram_waddr), 64'd3);
    tick();
    wr_req = 2'b10;
    @(negedge clk);
    chk("lit_wr_second", 64'(wr_gnt), 64'h2);
    chk("lit_wr_second_data", 64'(ram_wdata), 64'h77777777);
    tick();
    wr_req = 2'b00;

    // both readers contend continuously
    rd_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lit_rd_alt_gnt", 64'(rd_gnt), (i % 2 == 0) ? 64'h1 : 64'h2);
      if (i > 0) begin
        chk("lit_rd_alt_valid", 64'(rd_valid), (i % 2 == 0) ? 64'h2 : 64'h1);
        chk("lit_rd_alt_data", 64'(rd_data), (i % 2 == 0) ? 64'h77777777 : 64'h11111111);
      end
      tick();
    end
    rd_req = 2'b00;
    @(negedge clk);
    chk("lit_rd_last_valid", 64'(rd_valid), 64'h2);
    chk("lit_rd_last_data", 64'(rd_data), 64'h77777777);
    tick();

    // same-cycle read and write to addr 5 returns old data
    wr_req = 2'b01; wr_addr = {5'd7, 5'd5}; wr_data = {32'h77777777, 32'hDEADBEEF};
    rd_req = 2'b10; rd_addr = {5'd5, 5'd5};
    @(negedge clk);
    chk("lit_rw_wgnt", 64'({rd_gnt, wr_gnt}), 64'b1001);
    tick();
    wr_req = 2'b00; rd_req = 2'b01;
    @(negedge clk);
    chk("lit_rw_old_data", 64'(rd_data), 64'd0);
    chk("lit_rw_old_valid", 64'(rd_valid), 64'h2);
    tick();
    rd_req = 2'b00;
    @(negedge clk);
    chk("lit_rw_new_data", 64'(rd_data), 64'hDEADBEEF);
    tick();

    // writer1 alone twice, then both writers
    wr_addr = {5'd9, 5'd10}; wr_data = {32'h99999999, 32'hAAAAAAAA};
    for (int i = 0; i < 4; i++) begin
      wr_req = wreq[i];
      @(negedge clk);
      chk("lit_wr_seq", 64'(wr_gnt), 64'(wexp[i]));
      tick();
    end
    wr_req = 2'b00;

    // reset pulse right after a read grant
    rd_req = 2'b01; rd_addr = {5'd7, 5'd3};
    @(negedge clk);
    chk("lit_pre_rst_gnt", 64'(rd_gnt), 64'h1);
    tick();
    reset_n = 1'b0; rd_req = 2'b00;
    @(negedge clk);
    chk("lit_rst_drop_valid", 64'(rd_valid), 64'd0);
    chk("lit_rst_done_low", 64'(init_done), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    run_init();

    rd_req = 2'b01; rd_addr = {5'd5, 5'd5};
    @(negedge clk);
    chk("lit_post_gnt", 64'(rd_gnt), 64'h1);
    tick();
    rd_req = 2'b00;
    @(negedge clk);
    chk("lit_post_valid", 64'(rd_valid), 64'h1);
    chk("lit_post_cleared", 64'(rd_data), 64'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule

// File: doc/ram_rr_arbiter.md
RAM_RR_ARBITER -- requirements
Module: ram_rr_arbiter

Interface
- REQ-001 SHALL have parameter ADDR_W, default 5: RAM address width.
- REQ-002 SHALL have parameter DATA_W, default 32: RAM data width.
- REQ-003 SHALL have parameter DEPTH, default 32: number of RAM entries, at most 2^ADDR_W.
- REQ-004 Clocking and reset are decided: one clock; reset is asynchronous and active-low.
- REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
- REQ-007 SHALL have port rd_req, input, 2 bits: read request, one bit per read requester.
- REQ-008 SHALL have port rd_addr, input, 2*ADDR_W bits: read addresses, packed {req1, req0}.
- REQ-009 SHALL have port rd_gnt, output, 2 bits: one-hot-or-zero read grant, combinational.
- REQ-010 SHALL have port rd_valid, output, 2 bits: one-hot-or-zero read response strobe.
- REQ-011 SHALL have port rd_data, output, DATA_W bits: read response data, shared by both requesters.
- REQ-012 SHALL have port wr_req, input, 2 bits: write request, one bit per write requester.
- REQ-013 SHALL have port wr_addr, input, 2*ADDR_W bits: write addresses, packed {req1, req0}.
- REQ-014 SHALL have port wr_data, input, 2*DATA_W bits: write data, packed {req1, req0}.
- REQ-015 SHALL have port wr_gnt, output, 2 bits: one-hot-or-zero write grant, combinational.
- REQ-016 SHALL have port init_done, output, 1 bit: high once the RAM clear has completed.
- REQ-017 SHALL have port ram_raddr, output, ADDR_W bits: drives the 1R1W sync RAM read address.
- REQ-018 SHALL have port ram_rdata, input, DATA_W bits: RAM read data, valid one cycle after ram_raddr.
- REQ-019 SHALL have ports ram_waddr (ADDR_W), ram_wdata (DATA_W) and ram_we (1), all outputs: RAM write port.

Function
- REQ-020 SHALL implement a two-state FSM, INIT and RUN; reset enters INIT.
- REQ-021 In INIT, SHALL drive ram_we=1, ram_waddr=cnt and ram_wdata=0, with cnt counting 0..DEPTH-1 one per cycle.
- REQ-022 In INIT, SHALL hold rd_gnt and wr_gnt at 0 and ignore all requests.
- REQ-023 On the cycle writing DEPTH-1, SHALL transition to RUN; init_done SHALL be 1 from the next cycle onward.
- REQ-024 In RUN, SHALL grant a sole requester immediately, in the same cycle as its request.
- REQ-025 On read contention, SHALL grant the requester selected by 1-bit pointer rd_ptr.
- REQ-026 On every read grant, SHALL set rd_ptr to the non-granted index; no grant leaves rd_ptr unchanged.
- REQ-027 Write arbitration SHALL be identical, using an independent pointer wr_ptr.
- REQ-028 A transfer occurs when req&gnt; requesters SHALL hold req, addr and data stable until granted; the arbiter need not check this.
- REQ-029 ram_raddr SHALL be the granted read address, or 0 with no read grant.
- REQ-030 In RUN, ram_we SHALL equal |wr_gnt, with ram_waddr/ram_wdata taken from the granted writer (0 if none).
- REQ-031 rd_valid SHALL be rd_gnt registered, i.e. 1-cycle latency; rd_data SHALL pass ram_rdata through combinationally.
- REQ-032 One read and one write MAY be granted in the same cycle.
- REQ-033 On a same-cycle read and write to the same address, the read SHALL return the old data; no bypass.
- REQ-034 Back-to-back grants to the same requester SHALL be allowed every cycle when no contention exists.

Reset
- REQ-035 reset_n low SHALL asynchronously set state=INIT, cnt=0, rd_ptr=0, wr_ptr=0, rd_valid=0 and init_done=0.
- REQ-036 While reset_n is low, rd_gnt, wr_gnt and ram_we SHALL be 0.
- REQ-037 Reset asserted mid-RUN SHALL drop any in-flight read response (no rd_valid) and restart a full clear on release.

Verification
- REQ-038 Release reset (DEPTH=32): ram_we=1 for 32 cycles, addr 0..31, data 0; init_done=1 in cycle 33; no grants meanwhile despite rd_req=wr_req=2'b11.
- REQ-039 Both readers request continuously at addr 3 and 7 after init: rd_gnt = 01,10,01,10...; rd_valid mirrors it one cycle later, with the data of the matching address.
- REQ-040 Writer0 writes addr 5 = 0xDEADBEEF while reader1 reads addr 5 in the same cycle: rd_data=0; a next read of addr 5 returns 0xDEADBEEF.
- REQ-041 Writer1 alone for 2 cycles, then both writers request: wr_gnt = 10,10,01,10.
- REQ-042 reset_n pulsed low the cycle after a read grant: rd_valid stays 0, init_done=0, and a fresh 32-cycle clear follows release.
- REQ-043 DEPTH=8, ADDR_W=3: clear covers addr 0..7 only; init_done=1 in cycle 9.
